// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
package pipeline_pkg;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    REDIR_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode/execute register-usage bundle feeding the load-use comparator.
interface pipeline_ctrl_if;
  logic [4:0] rs1D;
  logic [4:0] rs2D;
  logic       use_rs1D;
  logic       use_rs2D;
  logic [4:0] rdE;
  logic       is_loadE;
  logic       load_use;

  modport master (
    output rs1D, rs2D, use_rs1D, use_rs2D, rdE, is_loadE,
    input  load_use
  );

  modport slave (
    input  rs1D, rs2D, use_rs1D, use_rs2D, rdE, is_loadE,
    output load_use
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in E whose destination feeds D.
module hazard_detect (
  pipeline_ctrl_if.slave hz
);
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign rs1_hit     = hz.use_rs1D && (hz.rs1D == hz.rdE);
  assign rs2_hit     = hz.use_rs2D && (hz.rs2D == hz.rdE);
  assign hz.load_use = hz.is_loadE && (hz.rdE != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/redirect controller with stall and flush counters.
//
// state      | meaning
// RUN        | normal flow; redirects complete in their capture cycle
// REDIR_WAIT | redirect pending in pend_pc until fetch accepts it
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             use_rs1D,
  input  logic             use_rs2D,
  input  logic [4:0]       rdE,
  input  logic             is_loadE,
  input  logic             dmem_busy,
  input  logic             fetch_ready,
  input  logic             fail_predictD,
  input  logic             fail_predictE,
  input  logic [31:0]      targetD,
  input  logic [31:0]      targetE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e            state_q, state_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              load_use;
  logic              capture;
  logic [31:0]       cap_pc;

  pipeline_ctrl_if hz_if ();

  assign hz_if.rs1D     = rs1D;
  assign hz_if.rs2D     = rs2D;
  assign hz_if.use_rs1D = use_rs1D;
  assign hz_if.use_rs2D = use_rs2D;
  assign hz_if.rdE      = rdE;
  assign hz_if.is_loadE = is_loadE;
  assign load_use       = hz_if.load_use;

  hazard_detect u_hazard (
    .hz (hz_if.slave)
  );

  // A memory stall freezes everything, so mispredictions are only taken when dmem is ready.
  // E is older than D, so its redirect wins when both fire.
  assign capture = !RST && !dmem_busy && (fail_predictD || fail_predictE);
  assign cap_pc  = fail_predictE ? targetE : targetD;

  // State register, pending PC and counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      pend_pc_q   <= NOP;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state, pending-PC and counter update
  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stallF};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, capture};
    if (!dmem_busy) begin
      if (capture) begin
        if (fetch_ready) begin
          state_d = RUN;
        end else begin
          state_d   = REDIR_WAIT;
          pend_pc_d = cap_pc;
        end
      end else if (state_q == REDIR_WAIT && fetch_ready) begin
        state_d = RUN;
      end
    end
  end

  // Stall, flush and redirect outputs
  always_comb begin
    stallF         = 1'b0;
    stallD         = 1'b0;
    stallE         = 1'b0;
    flushD         = 1'b0;
    flushE         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = NOP;
    if (!RST) begin
      if (state_q == REDIR_WAIT) begin
        redirect_valid = 1'b1;
        redirect_pc    = pend_pc_q;
      end
      if (dmem_busy) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
      end else if (capture) begin
        flushD         = 1'b1;
        flushE         = fail_predictE;
        redirect_valid = 1'b1;
        redirect_pc    = cap_pc;
      end else begin
        flushD = (state_q == REDIR_WAIT);
        if (load_use) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-002 SHALL have port CLK, in, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, in, 1: synchronous, active-high reset.
REQ-004 SHALL have ports rs1D, rs2D, in, 5 each: decode-stage source registers.
REQ-005 SHALL have ports use_rs1D, use_rs2D, in, 1 each: the decode instruction reads rs1D/rs2D.
REQ-006 SHALL have ports rdE (in, 5) and is_loadE (in, 1): execute-stage destination register and load flag.
REQ-007 SHALL have port dmem_busy, in, 1: data memory not ready; freezes the whole pipeline.
REQ-008 SHALL have port fetch_ready, in, 1: fetch accepts a redirect and produces a valid instruction this cycle.
REQ-009 SHALL have ports fail_predictD, fail_predictE, in, 1 each: misprediction detected in D / E.
REQ-010 SHALL have ports targetD, targetE, in, 32 each: correct next PC for the D / E misprediction.
REQ-011 SHALL have ports stallF, stallD, stallE, out, 1 each: hold the F / D / E stage registers.
REQ-012 SHALL have ports flushD, flushE, out, 1 each: load a bubble (inst = 0) into D / E.
REQ-013 SHALL have ports redirect_valid (out, 1) and redirect_pc (out, 32): PC redirect to fetch.
REQ-014 SHALL have ports stall_cnt, flush_cnt, out, CNT_W each: counts of stall cycles and flush events.

Function
REQ-015 SHALL implement an FSM with states RUN and REDIR_WAIT, plus a 32-bit pend_pc register.
REQ-016 SHALL assert load-use hazard when all hold: is_loadE = 1, rdE != 0, and (use_rs1D && rs1D == rdE or use_rs2D && rs2D == rdE).
REQ-017 SHALL, on load-use with dmem_busy = 0, assert stallF = stallD = 1 and flushE = 1 for exactly that cycle, with no state change.
REQ-018 SHALL, while dmem_busy = 1, assert stallF = stallD = stallE = 1 and flushD = flushE = 0, ignore fail_predict*, and leave the state and pend_pc unchanged.
REQ-019 SHALL, on fail_predictE with dmem_busy = 0, assert flushD = flushE = 1 and capture targetE as the redirect.
REQ-020 SHALL, on fail_predictD alone with dmem_busy = 0, assert flushD = 1 and capture targetD as the redirect.
REQ-021 SHALL, when fail_predictD and fail_predictE are both asserted, act on E only.
REQ-022 SHALL give misprediction priority over load-use in the same cycle: flush only, stallF = stallD = 0.
REQ-023 SHALL drive redirect_valid and redirect_pc combinationally in the capture cycle.
REQ-024 SHALL, if fetch_ready = 1 in the capture cycle, complete the redirect and stay in RUN.
REQ-025 SHALL otherwise write pend_pc and go to REDIR_WAIT.
REQ-026 SHALL, in REDIR_WAIT, drive redirect_valid = 1 and redirect_pc = pend_pc, and assert flushD every cycle.
REQ-027 SHALL, in REDIR_WAIT, return to RUN on the first cycle with fetch_ready = 1 and dmem_busy = 0.
REQ-028 SHALL, when a new misprediction arrives in REDIR_WAIT, overwrite pend_pc and take its flushes; the newest capture always wins.
REQ-029 SHALL increment stall_cnt by 1 in every cycle with stallF = 1.
REQ-030 SHALL increment flush_cnt by 1 per captured misprediction.
REQ-031 SHALL let both counters wrap modulo 2^CNT_W.
REQ-032 SHALL keep redirect_valid = 0 and redirect_pc = 0 in RUN with no capture.

Reset
REQ-033 SHALL, with RST = 1 at a clock edge, set state RUN, pend_pc = 0 and both counters = 0, overriding any pending redirect.
REQ-034 SHALL hold all stall, flush and redirect outputs at 0 while RST = 1.

Structure
REQ-035 SHALL place the FSM state encoding and the NOP constant 32'h00000000 in the shared package pipeline_pkg.
REQ-036 SHALL implement the load-use comparison as the combinational sub-module hazard_detect.
REQ-037 SHALL keep the FSM, pend_pc and counters in pipeline_ctrl.

Verification
REQ-038 SHALL test load-use: is_loadE = 1, rdE = 5, rs1D = 5, use_rs1D = 1 -> stallF = stallD = flushE = 1 for 1 cycle; stall_cnt = 1.
REQ-039 SHALL test x0: is_loadE = 1, rdE = 0, rs2D = 0, use_rs2D = 1 -> no stall or flush.
REQ-040 SHALL test fail_predictE and fail_predictD together with targetE = 0x8040, targetD = 0x8100, fetch_ready = 1 -> flushD = flushE = 1, redirect_pc = 0x8040; flush_cnt = 1.
REQ-041 SHALL test fail_predictD with targetD = 0x8020, fetch_ready = 0 for 3 cycles -> REDIR_WAIT; redirect_pc = 0x8020 held; flushD = 1 each cycle; RUN after fetch_ready = 1.
REQ-042 SHALL test dmem_busy = 1 for 4 cycles during a load-use -> all stalls = 1, no flush; stall_cnt += 4; then the 1-cycle load-use bubble.
REQ-043 SHALL test RST = 1 during REDIR_WAIT -> next cycle RUN, redirect_valid = 0, counters = 0.
